// File: rtl/crc5_token_sched.sv
// Round-robin front end that shares one serial CRC5 engine between a token
// builder (requester 0) and an SOF frame-number builder (requester 1).
// The winning payload is fed to the engine LSB first, the five CRC bits the
// engine streams back are collected and returned with the owner's ID, and a
// watchdog turns a hung engine into an error response.
module crc5_token_sched #(
  parameter int PLEN    = 11,
  parameter int TIMEOUT = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [PLEN-1:0] req_data0,
  input  logic [PLEN-1:0] req_data1,
  output logic [1:0]      req_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [4:0]      resp_crc,
  output logic            resp_err,
  output logic            crc_start,
  output logic            crc_s_in,
  input  logic            crc_out,
  input  logic            crc_ready,
  input  logic            crc_done,
  output logic            busy
);

  localparam int BW = $clog2(PLEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_COLLECT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PLEN-1:0] shreg;
  logic [BW-1:0]   bit_cnt;
  logic [2:0]      col_cnt;
  logic [WW-1:0]   wdog;
  logic [4:0]      crc_reg;
  logic            id_q;
  logic            err_q;
  logic            rr_last;

  logic            grant_any;
  logic            grant_id;
  logic            last_bit;
  logic            wdog_expired;
  logic            take_bit;
  logic [2:0]      col_after;

  // When both requesters are valid the one that did not win last time gets it.
  assign grant_any    = |req_valid;
  assign grant_id     = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
  assign last_bit     = (bit_cnt == BW'(PLEN - 1));
  assign wdog_expired = (wdog == WW'(TIMEOUT - 1));
  // Only the first five engine bits are the CRC; later ready pulses are dropped.
  assign take_bit     = crc_ready && (col_cnt < 3'd5);
  assign col_after    = col_cnt + {2'b00, take_bit};

  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_id    = resp_valid & id_q;
  assign resp_err   = resp_valid & err_q;
  assign resp_crc   = resp_valid ? crc_reg : 5'b0;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values and process order cannot matter.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_nxt = state;
    req_ready = 2'b00;
    crc_start = 1'b0;
    crc_s_in  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_nxt = S_START;
        end
      end
      S_START: begin
        crc_start = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        crc_s_in = shreg[0];
        if (wdog_expired)  state_nxt = S_RESP;
        else if (last_bit) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (crc_done || wdog_expired) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job datapath: payload shifter, counters, collected CRC and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      col_cnt <= '0;
      wdog    <= '0;
      crc_reg <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            shreg   <= grant_id ? req_data1 : req_data0;
            id_q    <= grant_id;
            rr_last <= grant_id;
          end
        end
        S_START: begin
          bit_cnt <= '0;
          col_cnt <= '0;
          crc_reg <= '0;
          err_q   <= 1'b0;
          // The START cycle itself is the first watched cycle.
          wdog    <= WW'(1);
        end
        S_FEED: begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + BW'(1);
          wdog    <= wdog + WW'(1);
          if (wdog_expired) begin
            err_q   <= 1'b1;
            crc_reg <= '0;
          end
        end
        S_COLLECT: begin
          wdog <= wdog + WW'(1);
          if (take_bit) begin
            crc_reg <= {crc_reg[3:0], crc_out};
            col_cnt <= col_after;
          end
          // A bit arriving with done is kept; a short stream is an error.
          if (crc_done) begin
            if (col_after < 3'd5) err_q <= 1'b1;
          end else if (wdog_expired) begin
            err_q   <= 1'b1;
            crc_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/crc5_token_sched.md
Name: crc5_token_sched

Overview:
- Round-robin scheduler that shares one serial CRC5 engine between two requesters: 0 = token builder, 1 = SOF frame-number builder.
- Accepts an 11-bit payload (addr+endp, or frame number) from the winning requester, starts the engine, and serializes the payload LSB first.
- Captures the 5 CRC bits the engine streams back and returns them with a requester ID.
- A watchdog flags an engine that never completes.

Parameters:
- PLEN, 11, payload width in bits; the engine's fixed bit count.
- TIMEOUT, 40, cycles allowed from crc_start to crc_done before an error is declared.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req_valid  input  2  request valid, one bit per requester
- req_data0  input  11  payload, requester 0
- req_data1  input  11  payload, requester 1
- req_ready  output  2  request accepted, one-hot pulse
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  1  requester that owns the result
- resp_crc  output  5  CRC bits; resp_crc[4] is the first bit the engine streams
- resp_err  output  1  timeout occurred; resp_crc is then 5'b0
- crc_start  output  1  one-cycle engine start pulse
- crc_s_in  output  1  serial payload bit to the engine
- crc_out  input  1  serial CRC bit from the engine
- crc_ready  input  1  crc_out is valid this cycle
- crc_done  input  1  engine finished, one-cycle pulse
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, rr_last=1 so requester 0 wins first. Reset mid-operation aborts immediately and drops any in-flight payload or result.
- IDLE:
  - If any req_valid is set, grant one: the single requester if only one is valid; if both, the one not equal to rr_last.
  - In the grant cycle: req_ready[g]=1 (1 cycle), latch payload into shift reg, id<=g, rr_last<=g, go START.
- START: crc_start=1 for exactly 1 cycle, clear bit counter and watchdog, go FEED.
- FEED:
  - crc_s_in = shreg[0]; shift right each cycle.
  - Bit k (k=0..PLEN-1) is driven in the (k+1)th cycle after the START cycle, so exactly PLEN cycles are spent in FEED.
  - After the last bit: crc_s_in=0, go COLLECT.
- COLLECT:
  - crc_s_in=0.
  - Each cycle crc_ready=1: crc_reg <= {crc_reg[3:0], crc_out}, collect counter +1.
  - crc_ready pulses beyond 5 are ignored (collect counter saturates at 5).
  - On crc_done: go RESP. If crc_ready and crc_done are in the same cycle, sample the bit first.
  - If crc_done arrives with fewer than 5 bits collected, err=1.
- Watchdog:
  - Counts every cycle from START through COLLECT.
  - On reaching TIMEOUT without crc_done: err=1, crc_reg cleared, go RESP.
- RESP:
  - resp_valid=1 with resp_id, resp_crc, resp_err held stable until resp_ready.
  - The handshake completes in the cycle resp_valid&resp_ready; go IDLE next cycle.
  - No new grant is issued in the same cycle as response completion (minimum one IDLE cycle between jobs).
- Arbitration:
  - req_valid is sampled only in IDLE; changes in other states are ignored.
  - The requester holds req_valid and its data until req_ready.
- Counter widths are sized to hold PLEN and TIMEOUT; no wrap-around is possible.
- Minimum job latency from grant to resp_valid: 1 + 1 + PLEN + engine latency.

Test Plan:
- Single request, requester 0, data 11'h001, model engine returns bits 1,0,1,1,0 then done:
  - req_ready=2'b01 for 1 cycle; crc_start pulses once.
  - crc_s_in shows 1 then ten 0s.
  - resp_valid with resp_id=0, resp_crc=5'b10110, resp_err=0.
- Both requesters valid continuously, 4 jobs:
  - Grants alternate 0,1,0,1.
  - Each resp_id matches its grant.
  - No overlapping crc_start pulses.
- Back-pressure: hold resp_ready=0 for 10 cycles:
  - resp_valid and resp_crc stay stable.
  - No req_ready is issued to the still-valid other requester until after the handshake.
- Engine never asserts crc_done:
  - Exactly TIMEOUT cycles after crc_start, resp_valid=1, resp_err=1, resp_crc=0.
- Engine asserts crc_done after only 3 ready bits:
  - resp_err=1.
- Assert rst in the middle of FEED:
  - Next cycle all outputs are 0 and busy=0.
  - A new request afterwards is granted to requester 0 and completes normally.
